traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised intersection phase controller for N lanes. Grants a green phase to one lane at a time, with a yellow phase and an optional all-red phase between grants. Normal traffic is served round-robin; jammed lanes get priority and pre-empt normal green. The block holds its own phase timers, so the old normal/jam counter and grant-generator blocks sit inside it, and it drives the top-level `allow`/`warn` lamps directly.

## Interface
Parameters:
- `N_LANES`, 4: number of lanes; must be ≥ 2.
- `GREEN_CYCLES`, 16: normal green duration in cycles; ≥ 1.
- `JAM_GREEN_CYCLES`, 32: jam green duration in cycles; ≥ 1.
- `YELLOW_CYCLES`, 4: yellow duration in cycles; ≥ 1.
- `ALLRED_CYCLES`, 2: all-red clearance in cycles; ≥ 1. Used only with the macro.
- `MAX_EXT`, 2: maximum consecutive jam-green extensions.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `traffic_jam`  in  N_LANES  per-lane jam flag, level, synchronous to `clk`.
- `allow`  out  N_LANES  one-hot green lamp; all zero when no lane is green.
- `warn`  out  N_LANES  one-hot yellow lamp.
- `mode`  out  2  mode of the current grant: 0 = IDLE, 1 = NORMAL, 2 = JAM.
- `active_lane`  out  LANE_W  lane of the current or most recent grant; LANE_W = max(1, $clog2(N_LANES)).

## Operation
States: IDLE, GREEN, YELLOW, ALLRED.

- **IDLE.** Lasts exactly one cycle after reset release, then performs a pick and moves to GREEN.
- **Pick.** Performed in the cycle that leaves IDLE, YELLOW or ALLRED.
  - If any bit of `traffic_jam` is set: choose the first jammed lane in rotating priority starting at `ptr+1` (wrapping). The grant is a jam grant: timer loaded with JAM_GREEN_CYCLES, `mode` = 2.
  - Otherwise: choose lane `ptr+1` (mod N_LANES). The grant is a normal grant: timer loaded with GREEN_CYCLES, `mode` = 1.
  - `ptr` and `active_lane` are updated to the chosen lane.
- **GREEN, normal grant.** If any jam bit for a lane other than `active_lane` is set, go to YELLOW on the next edge (pre-emption). A jam on `active_lane` itself does not pre-empt. Otherwise go to YELLOW when the timer reaches 0.
- **GREEN, jam grant.** Never pre-empted. At timer 0:
  - If `traffic_jam[active_lane]` is still set, no other jam bit is set, and `ext_cnt` < MAX_EXT: reload the timer with JAM_GREEN_CYCLES, increment `ext_cnt`, and stay in GREEN.
  - Otherwise go to YELLOW. `ext_cnt` clears on every pick.
- **YELLOW.** Goes to ALLRED (macro defined) or straight to pick and GREEN (macro undefined) when the timer reaches 0.
- **ALLRED.** `allow` = `warn` = 0; pick and go to GREEN when the timer reaches 0.
- **Outputs.** `allow[active_lane]` = 1 only in GREEN; `warn[active_lane]` = 1 only in YELLOW. `allow` and `warn` are never both non-zero in the same cycle.

## Timing
- **Reset values.** State IDLE; `allow` = 0; `warn` = 0; `mode` = 0; `active_lane` = 0; `ptr` = N_LANES-1, so the first normal grant is lane 0; timer = 0; `ext_cnt` = 0. Reset takes effect asynchronously, including in the middle of a phase.
- **Timer.** Loaded with duration-1 on state entry, decrements every cycle, and the exit condition is timer == 0. Each phase therefore lasts exactly its parameter in cycles. Timer width is CNT_W = $clog2(max duration + 1). No wrap is possible.
- **Registered outputs.** `allow`, `warn`, `mode` and `active_lane` are registered and change on the same edge as the state register.
- **Pre-emption latency.** A jam bit sampled high at edge k causes GREEN→YELLOW at edge k+1.
- **Pick sampling.** Jam inputs are sampled on the edge that leaves YELLOW or ALLRED. A jam that drops before that edge is ignored.

## Configuration
- `TRAFFIC_ALLRED_EN`
  - Defined: the ALLRED state and its ALLRED_CYCLES clearance exist.
  - Undefined: YELLOW goes directly to the next GREEN, and ALLRED_CYCLES is unused.

## Structure
- **Package `traffic_pkg`.** State enum, mode encoding (MODE_IDLE/NORMAL/JAM), and the LANE_W/CNT_W helper functions.
- **Sub-module `rr_pick`.** Combinational rotating-priority picker with inputs `req[N]` and `ptr` and outputs `grant_idx` and `valid`. Used for jam selection; the normal pick is a plain `ptr+1` increment.

## Test plan
Parameters for these scenarios: N=4, G=4, JG=6, Y=2, AR=1.
1. **No jams, macro on.** Reset, release. Required: `allow` one-hot over lanes 0, 1, 2, 3, 0, each green 4 cycles, then `warn` 2 cycles, then 1 all-red cycle; `mode` = 1 throughout.
2. **Pre-emption.** Set `traffic_jam` = 4'b0100 during the second cycle of lane 0 green. Required: lane 0 yellow on the next edge; then lane 2 green for 6 cycles with `mode` = 2.
3. **Competing jams.** Hold `traffic_jam` = 4'b1010 continuously. Required: jam grants alternate 1, 3, 1, 3 with no extensions, because another jam is always pending.
4. **Extension limit.** Hold only `traffic_jam[2]`. Required: lane 2 green lasts 6 × (1 + MAX_EXT) = 18 cycles, then yellow, then lane 3 is picked only after the jam clears, otherwise lane 2 again.
5. **Reset mid-phase.** Assert `rst_n` low mid-green. Required: `allow` = 0 immediately, without waiting for a clock edge; after release, lane 0 is green again following one IDLE cycle.
6. **Macro off.** Repeat scenario 1 with `TRAFFIC_ALLRED_EN` undefined. Required: `warn` falls on the same edge that the next lane's `allow` rises.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the intersection phase controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_ALLRED = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_NORMAL = 2'd1,
      MODE_JAM    = 2'd2
   } mode_t;

   // Width needed to hold values 0..n-1, never narrower than one bit.
   function automatic int lane_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_pick.sv
// Rotating-priority picker: first set request after ptr, wrapping; purely combinational.
module rr_pick
   import traffic_pkg::*;
#(
   parameter int N = 4,
   parameter int W = lane_w(N)
)(
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant_idx,
   output logic         valid
);

   // Scan from farthest to nearest so the nearest request after ptr wins.
   always_comb begin
      grant_idx = '0;
      valid     = |req;
      for (int i = N; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            grant_idx = W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Lane phase controller: GREEN/YELLOW(/ALLRED) sequencing with jam priority, registered lamps.
// TRAFFIC_ALLRED_EN adds an all-red clearance phase between yellow and the next green.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int N_LANES          = 4,
   parameter int GREEN_CYCLES     = 16,
   parameter int JAM_GREEN_CYCLES = 32,
   parameter int YELLOW_CYCLES    = 4,
   parameter int ALLRED_CYCLES    = 2,
   parameter int MAX_EXT          = 2,
   localparam int LANE_W          = lane_w(N_LANES)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_LANES-1:0] traffic_jam,
   output logic [N_LANES-1:0] allow,
   output logic [N_LANES-1:0] warn,
   output logic [1:0]         mode,
   output logic [LANE_W-1:0]  active_lane
);

   localparam int CNT_W = cnt_w(GREEN_CYCLES, JAM_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
   localparam int EXT_W = lane_w(MAX_EXT + 1);

   localparam logic [CNT_W-1:0]  T_GREEN   = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  T_JAM     = CNT_W'(JAM_GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  T_YELLOW  = CNT_W'(YELLOW_CYCLES - 1);
`ifdef TRAFFIC_ALLRED_EN
   localparam logic [CNT_W-1:0]  T_ALLRED  = CNT_W'(ALLRED_CYCLES - 1);
`endif
   localparam logic [EXT_W-1:0]  EXT_MAX   = EXT_W'(MAX_EXT);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

   state_t              r_state,  w_state_nxt;
   mode_t               r_mode,   w_mode_nxt;
   logic [CNT_W-1:0]    r_timer,  w_timer_nxt;
   logic [EXT_W-1:0]    r_ext,    w_ext_nxt;
   logic [LANE_W-1:0]   r_ptr,    w_ptr_nxt;
   logic [LANE_W-1:0]   r_lane,   w_lane_nxt;
   logic [N_LANES-1:0]  r_allow,  w_allow_nxt;
   logic [N_LANES-1:0]  r_warn,   w_warn_nxt;

   logic [LANE_W-1:0]   w_jam_idx;
   logic                w_jam_vld;
   logic [LANE_W-1:0]   w_norm_idx;
   logic                w_jam_other;
   logic                w_jam_self;
   logic                w_do_pick;

   function automatic logic [N_LANES-1:0] onehot(input logic [LANE_W-1:0] l);
      onehot    = '0;
      onehot[l] = 1'b1;
   endfunction

   rr_pick #(
      .N (N_LANES),
      .W (LANE_W)
   ) u_rr_pick (
      .req       (traffic_jam),
      .ptr       (r_ptr),
      .grant_idx (w_jam_idx),
      .valid     (w_jam_vld)
   );

   assign w_norm_idx  = (r_ptr == LAST_LANE) ? '0 : r_ptr + LANE_W'(1);
   assign w_jam_other = |(traffic_jam & ~onehot(r_lane));
   assign w_jam_self  = traffic_jam[r_lane];

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_timer_nxt = r_timer - CNT_W'(1);
      w_ext_nxt   = r_ext;
      w_ptr_nxt   = r_ptr;
      w_lane_nxt  = r_lane;
      w_do_pick   = 1'b0;

      case (r_state)
         ST_IDLE: w_do_pick = 1'b1;
         ST_GREEN: begin
            if (r_mode == MODE_JAM) begin
               if (r_timer == '0) begin
                  // A lone persisting jam keeps its green, up to EXT_MAX reloads.
                  if (w_jam_self && !w_jam_other && (r_ext < EXT_MAX)) begin
                     w_timer_nxt = T_JAM;
                     w_ext_nxt   = r_ext + EXT_W'(1);
                  end else begin
                     w_state_nxt = ST_YELLOW;
                     w_timer_nxt = T_YELLOW;
                  end
               end
            end else if (w_jam_other || (r_timer == '0)) begin
               w_state_nxt = ST_YELLOW;
               w_timer_nxt = T_YELLOW;
            end
         end
         ST_YELLOW: begin
            if (r_timer == '0) begin
`ifdef TRAFFIC_ALLRED_EN
               w_state_nxt = ST_ALLRED;
               w_timer_nxt = T_ALLRED;
`else
               w_do_pick   = 1'b1;
`endif
            end
         end
         ST_ALLRED: begin
            if (r_timer == '0) w_do_pick = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_do_pick) begin
         w_state_nxt = ST_GREEN;
         w_ext_nxt   = '0;
         if (w_jam_vld) begin
            w_lane_nxt  = w_jam_idx;
            w_mode_nxt  = MODE_JAM;
            w_timer_nxt = T_JAM;
         end else begin
            w_lane_nxt  = w_norm_idx;
            w_mode_nxt  = MODE_NORMAL;
            w_timer_nxt = T_GREEN;
         end
         w_ptr_nxt = w_lane_nxt;
      end

      w_allow_nxt = (w_state_nxt == ST_GREEN)  ? onehot(w_lane_nxt) : '0;
      w_warn_nxt  = (w_state_nxt == ST_YELLOW) ? onehot(w_lane_nxt) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_IDLE;
         r_timer <= '0;
         r_ext   <= '0;
         r_ptr   <= LAST_LANE;
         r_lane  <= '0;
         r_allow <= '0;
         r_warn  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_timer <= w_timer_nxt;
         r_ext   <= w_ext_nxt;
         r_ptr   <= w_ptr_nxt;
         r_lane  <= w_lane_nxt;
         r_allow <= w_allow_nxt;
         r_warn  <= w_warn_nxt;
      end
   end

   assign allow       = r_allow;
   assign warn        = r_warn;
   assign mode        = r_mode;
   assign active_lane = r_lane;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with N=4, G=4, JG=6, Y=2, AR=1, MAX_EXT=2.
// Expectations follow TRAFFIC_ALLRED_EN when it is defined for the build.
module tb_traffic_phase_ctrl;

`ifdef TRAFFIC_ALLRED_EN
   localparam int AR_EFF = 1;
`else
   localparam int AR_EFF = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] traffic_jam;
   logic [3:0] allow;
   logic [3:0] warn;
   logic [1:0] mode;
   logic [1:0] active_lane;

   int n_cmp;
   int n_err;

   traffic_phase_ctrl #(
      .N_LANES          (4),
      .GREEN_CYCLES     (4),
      .JAM_GREEN_CYCLES (6),
      .YELLOW_CYCLES    (2),
      .ALLRED_CYCLES    (1),
      .MAX_EXT          (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .traffic_jam (traffic_jam),
      .allow       (allow),
      .warn        (warn),
      .mode        (mode),
      .active_lane (active_lane)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] oh(input int l);
      logic [3:0] one;
      one = 4'b0001;
      return one << l;
   endfunction

   task automatic chk(input string tag, input logic [3:0] ea, input logic [3:0] ew,
                      input logic [1:0] em, input logic [1:0] el);
      logic [11:0] obs;
      logic [11:0] exp_v;
      obs   = {allow, warn, mode, active_lane};
      exp_v = {ea, ew, em, el};
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed allow=%b warn=%b mode=%0d lane=%0d, expected allow=%b warn=%b mode=%0d lane=%0d",
                tag, allow, warn, mode, active_lane, ea, ew, em, el);
      end
   endtask

   task automatic green(input string tag, input int lane, input logic [1:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_green%0d", tag, i), oh(lane), 4'b0000, m, 2'(lane));
      end
   endtask

   task automatic yellow(input string tag, input int lane, input logic [1:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_yellow%0d", tag, i), 4'b0000, oh(lane), m, 2'(lane));
      end
   endtask

   task automatic allred(input string tag, input int lane, input logic [1:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_allred%0d", tag, i), 4'b0000, 4'b0000, m, 2'(lane));
      end
   endtask

   task automatic phase(input string tag, input int lane, input logic [1:0] m, input int g);
      green(tag, lane, m, g);
      yellow(tag, lane, m, 2);
      allred(tag, lane, m, AR_EFF);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      traffic_jam = 4'b0000;

      @(negedge clk);
      chk("reset", 4'b0000, 4'b0000, 2'd0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle", 4'b0000, 4'b0000, 2'd0, 2'd0);

      // Plain round robin.
      phase("rr_l0", 0, 2'd1, 4);
      phase("rr_l1", 1, 2'd1, 4);
      phase("rr_l2", 2, 2'd1, 4);
      phase("rr_l3", 3, 2'd1, 4);

      // Jam on lane 2 pre-empts lane 0 in its second green cycle.
      green("pre_l0", 0, 2'd1, 2);
      traffic_jam = 4'b0100;
      yellow("pre_l0", 0, 2'd1, 2);
      allred("pre_l0", 0, 2'd1, AR_EFF);
      green("jam_l2", 2, 2'd2, 3);
      traffic_jam = 4'b0000;
      green("jam_l2b", 2, 2'd2, 3);
      yellow("jam_l2", 2, 2'd2, 2);
      allred("jam_l2", 2, 2'd2, AR_EFF);

      // Two competing jams alternate without extension.
      green("cmp_l3", 3, 2'd1, 1);
      traffic_jam = 4'b1010;
      yellow("cmp_l3", 3, 2'd1, 2);
      allred("cmp_l3", 3, 2'd1, AR_EFF);
      phase("cmp_j1a", 1, 2'd2, 6);
      phase("cmp_j3a", 3, 2'd2, 6);
      phase("cmp_j1b", 1, 2'd2, 6);
      green("cmp_j3b", 3, 2'd2, 5);
      traffic_jam = 4'b0100;
      green("cmp_j3b_end", 3, 2'd2, 1);
      yellow("cmp_j3b", 3, 2'd2, 2);
      allred("cmp_j3b", 3, 2'd2, AR_EFF);

      // Lone jam on lane 2: base green plus two extensions, then re-granted.
      phase("ext_l2", 2, 2'd2, 18);
      green("ext_l2_again", 2, 2'd2, 3);
      traffic_jam = 4'b0000;
      green("ext_l2_again_b", 2, 2'd2, 3);
      yellow("ext_l2_again", 2, 2'd2, 2);
      allred("ext_l2_again", 2, 2'd2, AR_EFF);
      green("post_l3", 3, 2'd1, 2);

      // Asynchronous reset mid-green.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 4'b0000, 4'b0000, 2'd0, 2'd0);
      @(negedge clk);
      chk("rst_held", 4'b0000, 4'b0000, 2'd0, 2'd0);
      rst_n = 1'b1;
      #1;
      chk("idle2", 4'b0000, 4'b0000, 2'd0, 2'd0);
      phase("rst_l0", 0, 2'd1, 4);
      green("rst_l1", 1, 2'd1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
